// File: rtl/fetch_adder_pkg.sv
// Shared constants for the fetch address adder: default width and mode-select encoding.
package fetch_adder_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic SEL_ADD  = 1'b0;
  localparam logic SEL_LOAD = 1'b1;

endpackage

// File: rtl/fetch_adder_core.sv
// Parameterised N-bit ripple-carry adder producing sum and carry-out.
module fetch_adder_core #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/fetch_adder.sv
// Next-fetch-address adder: add increment or load a target, with a registered copy of the result.
module fetch_adder
  import fetch_adder_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  input  logic         sel,
  output logic [N-1:0] out,
  input  logic         clk,
  input  logic         rst,
  output logic         cout,
  output logic [N-1:0] out_q,
  output logic         cout_q
);

  logic [N-1:0] sum;
  logic         sum_cout;
  logic [N-1:0] out_d;
  logic         cout_d;

  fetch_adder_core #(.N(N)) u_core (
    .a    (op1),
    .b    (op2),
    .sum  (sum),
    .cout (sum_cout)
  );

  always_comb begin
    out_d  = sum;
    cout_d = sum_cout;
    // A load bypasses the adder entirely, so no carry can leak out.
    if (sel == SEL_LOAD) begin
      out_d  = op2;
      cout_d = 1'b0;
    end
  end

  assign out  = out_d;
  assign cout = cout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_fetch_adder.sv
// Scoreboard bench for fetch_adder: stimulus pushes expected results, a monitor compares them.
module tb_fetch_adder;

  typedef enum int { K_C4, K_R4, K_C8, K_R8 } kind_e;

  typedef struct {
    string       name;
    kind_e       kind;
    logic [8:0]  exp;   // {cout, out} zero-extended
  } exp_t;

  exp_t q[$];
  int   pushed = 0;
  int   popped = 0;
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  bit         clk_run = 1'b0;
  logic       rst;

  logic [3:0] a4, b4, out4, outq4;
  logic       s4, cout4, coutq4;
  logic [7:0] a8, b8, out8, outq8;
  logic       s8, cout8, coutq8;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  fetch_adder #(.N(4)) dut4 (
    .op1(a4), .op2(b4), .sel(s4), .out(out4), .clk(clk), .rst(rst),
    .cout(cout4), .out_q(outq4), .cout_q(coutq4)
  );

  fetch_adder #(.N(8)) dut8 (
    .op1(a8), .op2(b8), .sel(s8), .out(out8), .clk(clk), .rst(rst),
    .cout(cout8), .out_q(outq8), .cout_q(coutq8)
  );

  task automatic push(input string name, input kind_e kind, input logic [8:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    q.push_back(e);
    pushed++;
    #2;
  endtask

  // Monitor: each expectation is sampled one time unit after it is posted.
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      wait (pushed > popped);
      #1;
      e = q.pop_front();
      popped++;
      case (e.kind)
        K_C4:    act = {4'b0, cout4, out4};
        K_R4:    act = {4'b0, coutq4, outq4};
        K_C8:    act = {cout8, out8};
        default: act = {coutq8, outq8};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step4(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic s, input logic [4:0] exp);
    @(negedge clk);
    a4 = a; b4 = b; s4 = s;
    #1;
    push({name, "_comb"}, K_C4, {4'b0, exp});
    @(posedge clk);
    #1;
    push({name, "_reg"}, K_R4, {4'b0, exp});
  endtask

  initial begin
    logic [8:0] m;
    rst = 1'b1;
    a4 = 4'h0; b4 = 4'h1; s4 = 1'b0;
    a8 = 8'h0; b8 = 8'h0; s8 = 1'b0;

    // Combinational result with no clock running at all.
    #10;
    push("add_0_1_noclk", K_C4, 9'h001);
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    push("reset_outq", K_R4, 9'h000);
    push("reset_outq8", K_R8, 9'h000);
    push("comb_during_rst", K_C4, 9'h001);

    @(negedge clk);
    rst = 1'b0;

    step4("add_1_4",   4'h1, 4'h4, 1'b0, 5'h05);
    step4("wrap_F_1",  4'hF, 4'h1, 1'b0, 5'h10);
    step4("load_3_A",  4'h3, 4'hA, 1'b1, 5'h0A);
    step4("load_F_F",  4'hF, 4'hF, 1'b1, 5'h0F);
    step4("add_F_F",   4'hF, 4'hF, 1'b0, 5'h1E);
    step4("add_2_3",   4'h2, 4'h3, 1'b0, 5'h05);

    // Reset mid-operation wins over capture; comb path stays live.
    @(negedge clk);
    rst = 1'b1; a4 = 4'h2; b4 = 4'h2; s4 = 1'b0;
    #1;
    push("rst_comb_pre", K_C4, 9'h004);
    push("rst_hold_pre", K_R4, 9'h005);
    @(posedge clk);
    #1;
    push("rst_clears", K_R4, 9'h000);
    push("rst_comb_post", K_C4, 9'h004);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push("first_after_rst", K_R4, 9'h004);

    // Register holds between edges while inputs move.
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h1;
    #1;
    push("hold_comb", K_C4, 9'h008);
    push("hold_reg", K_R4, 9'h004);
    @(posedge clk);
    #1;
    push("hold_capture", K_R4, 9'h008);

    // 8-bit strided sweep against an arithmetic model.
    for (int i = 0; i < 256; i += 17) begin
      for (int j = 0; j < 256; j += 51) begin
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          a8 = 8'(i); b8 = 8'(j); s8 = s[0];
          m  = s8 ? {1'b0, b8} : {1'b0, a8} + {1'b0, b8};
          #1;
          push("sweep8_comb", K_C8, m);
          @(posedge clk);
          #1;
          push("sweep8_reg", K_R8, m);
        end
      end
    end
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; s8 = 1'b0;
    #1;
    push("wrap8", K_C8, 9'h100);

    for (int t = 0; t < 100 && popped < pushed; t++) #1;
    if (popped < pushed) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d popped want %0d", popped, pushed);
    end
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
